// File: rtl/acorn_tag_gen_if.sv
// Handshake and data bundle between the encryption stage and the ACORN-128 tag generator.
interface acorn_tag_gen_if #(
  parameter int unsigned TAG_BITS = 128
);
  logic                start;
  logic [292:0]        state_in;
  logic                busy;
  logic                tag_valid;
  logic [TAG_BITS-1:0] tag;
  logic [292:0]        state_out;

  modport master (
    output start, state_in,
    input  busy, tag_valid, tag, state_out
  );

  modport slave (
    input  start, state_in,
    output busy, tag_valid, tag, state_out
  );
endinterface

// File: rtl/acorn_tag_gen.sv
// ACORN-128 finalization: runs FINAL_STEPS state updates (m=0, ca=1, cb=1) on a loaded
// state and collects the keystream of the last TAG_BITS steps as the authentication tag.
module acorn_tag_gen #(
  parameter int unsigned FINAL_STEPS = 768,
  parameter int unsigned TAG_BITS    = 128,
  parameter int unsigned CNT_W       = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  acorn_tag_gen_if.slave  tg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(FINAL_STEPS - 1);
  localparam logic [CNT_W-1:0] TAIL_START = CNT_W'(FINAL_STEPS - TAG_BITS);

  state_e              st_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [292:0]        state_q;
  logic [TAG_BITS-1:0] tag_q;
  logic                busy_q;
  logic                valid_q;

  logic [292:0]        mix;
  logic [292:0]        state_d;
  logic                ks_d;
  logic                fb;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic ch(input logic a, input logic b, input logic c);
    return (a & b) ^ (~a & c);
  endfunction

  // The six LFSR xors read only pre-update bits; ks and the feedback then read the mixed state.
  always_comb begin
    mix      = state_q;
    mix[289] = state_q[289] ^ state_q[235] ^ state_q[230];
    mix[230] = state_q[230] ^ state_q[196] ^ state_q[193];
    mix[193] = state_q[193] ^ state_q[160] ^ state_q[154];
    mix[154] = state_q[154] ^ state_q[111] ^ state_q[107];
    mix[107] = state_q[107] ^ state_q[66]  ^ state_q[61];
    mix[61]  = state_q[61]  ^ state_q[23]  ^ state_q[0];
    ks_d     = mix[12] ^ mix[154] ^ maj(mix[235], mix[61], mix[193])
             ^ ch(mix[230], mix[111], mix[66]);
    fb       = mix[0] ^ ~mix[107] ^ maj(mix[244], mix[23], mix[160]) ^ mix[196] ^ ks_d;
    state_d  = {fb, mix[292:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      tag_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (st_q)
        IDLE, DONE: begin
          if (tg.start) begin
            state_q <= tg.state_in;
            cnt_q   <= '0;
            tag_q   <= '0;
            busy_q  <= 1'b1;
            st_q    <= RUN;
          end else begin
            st_q    <= IDLE;
          end
        end
        RUN: begin
          state_q <= state_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          // Shifting in from the top leaves the first tail keystream bit at tag[0].
          if (cnt_q >= TAIL_START) begin
            tag_q <= {ks_d, tag_q[TAG_BITS-1:1]};
          end
          if (cnt_q == LAST_STEP) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            st_q    <= DONE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign tg.busy      = busy_q;
  assign tg.tag_valid = valid_q;
  assign tg.tag       = tag_q;
  assign tg.state_out = state_q;

endmodule
